// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity constants and default geometry
package uart_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_DEF = 8;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter with 3-sample majority vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    input  logic run,
    output logic bit_val,
    output logic sample_done,
    output logic bit_end
);
    localparam int CW = $clog2(PRESCALE);
    localparam int H = PRESCALE / 2;
    logic [CW-1:0] edge_cnt;
    logic [2:0] smp;
    assign bit_end = edge_cnt == CW'(PRESCALE - 1);
    assign sample_done = edge_cnt == CW'(H + 2);
    assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    always_ff @(posedge clk) begin
        if (!rst) begin
            edge_cnt <= '0;
            smp <= '0;
        end else begin
            edge_cnt <= (!run || bit_end) ? '0 : edge_cnt + 1'b1;
            if (edge_cnt >= CW'(H - 1) && edge_cnt <= CW'(H + 1)) smp <= {rx_in, smp[2:1]};
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and stop-bit check
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_err,
    output logic                  Stp_err
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    rx_state_t state, state_nx;
    logic [BW-1:0] bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic par_en_q, par_typ_q, par_bad;
    logic bit_val, sample_done, bit_end, start_seen, stop_end;
    assign start_seen = state == IDLE && !RX_IN;
    assign stop_end = state == STOP && bit_end;
    uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .clk(clk),
        .rst(rst),
        .rx_in(RX_IN),
        .run(start_seen || state != IDLE),
        .bit_val(bit_val),
        .sample_done(sample_done),
        .bit_end(bit_end)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = RX_IN ? IDLE : START;
            START:   if (bit_end) state_nx = bit_val ? IDLE : DATA;
            DATA:    if (bit_end && bit_cnt == BW'(DATA_WIDTH - 1)) state_nx = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_nx = STOP;
            STOP:    if (bit_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            bit_cnt <= '0;
            shreg <= '0;
            par_en_q <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad <= 1'b0;
            P_DATA <= '0;
            Data_Valid <= 1'b0;
            Par_err <= 1'b0;
            Stp_err <= 1'b0;
        end else begin
            state <= state_nx;
            bit_cnt <= state == DATA ? (bit_end ? bit_cnt + 1'b1 : bit_cnt) : '0;
            if (state == DATA && sample_done) shreg[bit_cnt] <= bit_val;
            if (start_seen) begin
                par_en_q <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_bad <= 1'b0;
            end
            if (state == PARITY && sample_done) par_bad <= (^shreg ^ par_typ_q) != bit_val;
            Stp_err <= stop_end && !bit_val;
            Par_err <= stop_end && bit_val && par_bad;
            Data_Valid <= stop_end && bit_val && !par_bad;
            if (stop_end && bit_val && !par_bad) P_DATA <= shreg;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a strobe scoreboard checked on every negedge
module tb_uart_rx;
    import uart_pkg::*;
    localparam int P = 8;
    localparam int W = 8;
    typedef struct {
        int kind;
        logic [W-1:0] data;
        int at;
    } exp_t;
    logic clk = 1'b0, rst = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [W-1:0] P_DATA;
    logic Data_Valid, Par_err, Stp_err;
    int vec = 0, err = 0, cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [W-1:0] model_pd = '0;
    uart_rx #(.DATA_WIDTH(W), .PRESCALE(P)) dut (
        .clk(clk),
        .rst(rst),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA),
        .Data_Valid(Data_Valid),
        .Par_err(Par_err),
        .Stp_err(Stp_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst) begin
            if (Data_Valid || Par_err || Stp_err) begin
                if (sb.size() == 0) chk("unexpected_strobe", {29'd0, Stp_err, Par_err, Data_Valid}, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("strobe_kind", {29'd0, Stp_err, Par_err, Data_Valid}, 32'd1 << mon_e.kind);
                    chk("strobe_cycle", cyc, mon_e.at);
                    chk("p_data", P_DATA, mon_e.data);
                end
            end else if (sb.size() > 0 && cyc > sb[0].at) begin
                chk("missed_strobe", cyc, sb[0].at);
                sb.delete(0);
            end
        end
    end
    task automatic idle(input int n);
        repeat (n) @(negedge clk) RX_IN = 1'b1;
    endtask
    task automatic send(input logic [W-1:0] d, input logic pen, input logic ptyp, input logic pbit,
                        input logic stp, input int spike, input int abort);
        logic [15:0] fr;
        logic [W-1:0] exp_d;
        int n, kind;
        fr = '0;
        for (int i = 0; i < W; i++) fr[1+i] = d[i];
        n = W + 1;
        if (pen) begin
            fr[n] = pbit;
            n++;
        end
        fr[n] = stp;
        n++;
        kind = !stp ? 2 : (pen && pbit != (^d ^ ptyp)) ? 1 : 0;
        PAR_EN = pen;
        PAR_TYP = ptyp;
        for (int k = 0; k < n * P; k++) begin
            @(negedge clk);
            if (k == abort) begin
                rst = 1'b0;
                RX_IN = 1'b1;
                @(negedge clk);
                chk("midrst_pdata", P_DATA, 0);
                chk("midrst_strobes", {29'd0, Stp_err, Par_err, Data_Valid}, 0);
                chk("midrst_state", dut.state, IDLE);
                rst = 1'b1;
                model_pd = '0;
                return;
            end
            if (k == 0 && abort < 0) begin
                exp_d = kind == 0 ? d : model_pd;
                model_pd = exp_d;
                sb.push_back('{kind, exp_d, cyc + n * P});
            end
            RX_IN = fr[k/P] ^ (k == spike);
            if (k == P) begin
                PAR_EN = ~pen;
                PAR_TYP = ~ptyp;
            end
        end
        PAR_EN = pen;
        PAR_TYP = ptyp;
    endtask
    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pdata", P_DATA, 0);
            chk("rst_strobes", {29'd0, Stp_err, Par_err, Data_Valid}, 0);
            chk("rst_state", dut.state, IDLE);
            RX_IN = ~RX_IN;
        end
        RX_IN = 1'b1;
        rst = 1'b1;
        idle(50);
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(5);
        send(8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, -1);
        send(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, -1);
        send(8'h3C, 1'b1, PAR_ODD, 1'b1, 1'b1, -1, -1);
        send(8'hC3, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, -1);
        idle(5);
        @(negedge clk) RX_IN = 1'b0;
        @(negedge clk) RX_IN = 1'b0;
        chk("glitch_in_start", dut.state, START);
        @(negedge clk) RX_IN = 1'b1;
        idle(6);
        chk("glitch_back_idle", dut.state, IDLE);
        idle(100);
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4 * P + 4, -1);
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(100);
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(10);
        send(8'h99, 1'b0, 1'b0, 1'b0, 1'b1, -1, 40);
        idle(100);
        send(8'h42, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(20);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the receive-side counterpart of the UART transmitter FSM/serializer/parity/mux path. It oversamples the serial line at PRESCALE clocks per bit, detects and validates the start bit, deserializes DATA_WIDTH bits LSB-first, and optionally checks parity. It then checks the stop bit and presents the word with a one-cycle valid strobe, or a one-cycle error strobe. It sits between the (externally synchronized) RX pin and the system-side consumer, on the same clock as the transmitter.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- PRESCALE, 8, clk cycles per bit; even, >= 8
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-low
- RX_IN  input  1  serial line, idle high, already synchronous to clk
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- P_DATA  output  DATA_WIDTH  last correctly received word
- Data_Valid  output  1  one-cycle strobe, P_DATA updated and good
- Par_err  output  1  one-cycle strobe, parity mismatch
- Stp_err  output  1  one-cycle strobe, stop bit sampled 0

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..PRESCALE-1 within a bit. bit_cnt counts 0..DATA_WIDTH-1.
- Bit value = majority of RX_IN samples at edge_cnt PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1. The value is valid from edge_cnt PRESCALE/2+2.
- IDLE: the cycle RX_IN=0 is first seen is sample 0 of the start bit. Next state is START with edge_cnt=1. PAR_EN and PAR_TYP are latched on this cycle and held for the frame.
- START: at end of bit (edge_cnt=PRESCALE-1):
  - sampled 0 -> DATA.
  - sampled 1 (glitch) -> IDLE, no strobe.
- DATA: the sampled bit is shifted into the shift register at bit position bit_cnt (LSB first). After bit DATA_WIDTH-1 ends, go to PARITY if PAR_EN, else STOP.
- PARITY: compute expected = XOR(data) XOR PAR_TYP and compare it with the sampled bit. The mismatch flag is held until the end of the frame.
- STOP: at edge_cnt=PRESCALE-1, go to IDLE and raise exactly one strobe on the next cycle:
  - Stp_err if stop bit = 0;
  - else Par_err if the parity flag is set;
  - else Data_Valid, and P_DATA is loaded from the shift register.
- P_DATA changes only with Data_Valid. It holds its value across errored frames.
- After Stp_err with the line still low (break), IDLE treats the low line as a new start bit. No special handling.
- Reset values (rst=0 at any clock edge, including mid-frame):
  - state IDLE, counters 0;
  - P_DATA 0;
  - Data_Valid, Par_err, Stp_err all 0;
  - latched parity configuration 0.

## Timing
- Frame length F = (10 + PAR_EN) bits for DATA_WIDTH=8, in general DATA_WIDTH + 2 + PAR_EN.
- If start sample 0 is at cycle T0, the strobe is high exactly in cycle T0 + F*PRESCALE, for one cycle.
- The strobe cycle coincides with the first IDLE cycle. Back-to-back frames therefore need no idle gap: a new start bit sample 0 may occur in the strobe cycle itself.
- Strobes never overlap and are never high for 2 consecutive cycles.
- Changing PAR_EN or PAR_TYP mid-frame has no effect until the next start detection.

## Structure
- Package uart_pkg holds:
  - state encoding (3-bit, IDLE=0);
  - PAR_EVEN=0 and PAR_ODD=1;
  - defaults for DATA_WIDTH and PRESCALE.
  - The transmitter side shares the parity constants.
- Sub-module uart_rx_sampler holds edge_cnt, the 3-sample capture and the majority vote. It outputs bit_val, sample_done (edge_cnt=PRESCALE/2+2) and bit_end (edge_cnt=PRESCALE-1).
- The top level holds the FSM, bit counter, shift register, parity check and output registers.

## Test plan
All scenarios use DATA_WIDTH=8 and PRESCALE=8.
- Reset: hold rst=0 for 3 cycles with RX_IN toggling -> all outputs 0 and state IDLE throughout. Release, with RX_IN=1 for 50 cycles -> no strobe.
- No parity: send 0xA5 with PAR_EN=0, start sample 0 at T0 -> Data_Valid high only at T0+80, P_DATA=0xA5, Par_err=Stp_err=0.
- Parity:
  - send 0x3C with PAR_EN=1, PAR_TYP=0, parity bit 0 -> Data_Valid at T0+88, P_DATA=0x3C;
  - resend with parity bit 1 -> Par_err at T0+88, Data_Valid=0, P_DATA stays 0x3C;
  - PAR_TYP=1 with parity bit 1 -> valid.
- Glitch and noise:
  - RX_IN low for 2 cycles, then high -> no frame, back in IDLE by the end of the start bit;
  - frame 0x00 with a 1-cycle high spike at edge_cnt 4 of bit 3 -> P_DATA=0x00, valid.
- Stop error: 0x81 with stop bit 0 -> Stp_err at T0+80, no Data_Valid, P_DATA unchanged. A following idle-high line gives no further strobes.
- Back-to-back and reset:
  - 0x55 then 0xFF with no gap -> Data_Valid at T0+80 and T0+160 with the correct P_DATA each time;
  - rst=0 for 1 cycle at T0+40 of a frame -> outputs 0, no strobe, and the next clean frame is received correctly.
